// File: rtl/instruction_prefetch_buffer.sv
`default_nettype none
// =============================================================================
// Module   : instruction_prefetch_buffer
// Desc     : Fetch stage with a single outstanding request and a DEPTH-entry
//            {instr, pc} FIFO feeding the decoder. IPB_STATS_EN adds counters.
// Revision : 1.0 - initial release
// =============================================================================
module instruction_prefetch_buffer #(
    parameter int INSTR_ADDR_WIDTH = 8,
    parameter int DEPTH            = 4,
    parameter int RESET_PC         = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        halt,
    input  logic                        redirect,
    input  logic [INSTR_ADDR_WIDTH-1:0] redirect_pc,
    output logic                        mem_req,
    output logic [INSTR_ADDR_WIDTH-1:0] mem_addr,
    input  logic                        mem_valid,
    input  logic [31:0]                 mem_instr,
    output logic                        instr_valid,
    input  logic                        instr_ready,
    output logic [31:0]                 instr,
    output logic [INSTR_ADDR_WIDTH-1:0] instr_pc,
    output logic [$clog2(DEPTH):0]      count
`ifdef IPB_STATS_EN
    ,
    output logic [31:0]                 stat_fetch,
    output logic [15:0]                 stat_flush
`endif
);

    localparam int                PTR_W   = $clog2(DEPTH);
    localparam int                CNT_W   = PTR_W + 1;
    localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);
    localparam logic [31:0]       NOP     = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_DISCARD = 2'd2
    } state_t;

    state_t                      state_q,    state_d;
    logic [INSTR_ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [INSTR_ADDR_WIDTH-1:0] req_pc_q,   req_pc_d;
    logic [PTR_W-1:0]            head_q,     head_d;
    logic [PTR_W-1:0]            tail_q,     tail_d;
    logic [CNT_W-1:0]            count_q,    count_d;
    logic [31:0]                 instr_mem_q [DEPTH];
    logic [INSTR_ADDR_WIDTH-1:0] pc_mem_q    [DEPTH];
    logic                        push;
    logic                        pop;

    assign instr_valid = (count_q != '0);
    assign instr       = instr_valid ? instr_mem_q[head_q] : NOP;
    assign instr_pc    = instr_valid ? pc_mem_q[head_q] : '0;
    assign count       = count_q;
    assign mem_addr    = fetch_pc_q;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        mem_req    = 1'b0;
        push       = 1'b0;
        pop        = 1'b0;

        if (redirect) begin
            // Flush wins over everything; an in-flight response must be dropped.
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
            fetch_pc_d = redirect_pc;
            case (state_q)
                S_WAIT:    state_d = mem_valid ? S_IDLE : S_DISCARD;
                S_DISCARD: if (mem_valid) state_d = S_IDLE;
                default:   state_d = state_q;
            endcase
        end else begin
            pop = instr_valid && instr_ready;
            case (state_q)
                S_IDLE: begin
                    // rst gating keeps the request low while reset is held.
                    if (rst && !halt && (count_q < DEPTH_C)) begin
                        mem_req    = 1'b1;
                        req_pc_d   = fetch_pc_q;
                        fetch_pc_d = fetch_pc_q + 1'b1;
                        state_d    = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (mem_valid) begin
                        push    = 1'b1;
                        state_d = S_IDLE;
                    end
                end
                S_DISCARD: begin
                    if (mem_valid) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
            if (push) tail_d = tail_q + 1'b1;
            if (pop)  head_d = head_q + 1'b1;
            if (push && !pop)      count_d = count_q + 1'b1;
            else if (pop && !push) count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            fetch_pc_q <= INSTR_ADDR_WIDTH'(RESET_PC);
            req_pc_q   <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem_q[tail_q] <= mem_instr;
            pc_mem_q[tail_q]    <= req_pc_q;
        end
    end

`ifdef IPB_STATS_EN
    logic [31:0] stat_fetch_q, stat_fetch_d;
    logic [15:0] stat_flush_q, stat_flush_d;

    always_comb begin
        stat_fetch_d = stat_fetch_q;
        stat_flush_d = stat_flush_q;
        if (push && (stat_fetch_q != '1))     stat_fetch_d = stat_fetch_q + 1'b1;
        if (redirect && (stat_flush_q != '1)) stat_flush_d = stat_flush_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_fetch_q <= '0;
            stat_flush_q <= '0;
        end else begin
            stat_fetch_q <= stat_fetch_d;
            stat_flush_q <= stat_flush_d;
        end
    end

    assign stat_fetch = stat_fetch_q;
    assign stat_flush = stat_flush_q;
`else
    // Statistics hardware not built.
`endif

endmodule
`default_nettype wire

// File: tb/tb_instruction_prefetch_buffer.sv
`default_nettype none
// =============================================================================
// Module   : tb_instruction_prefetch_buffer
// Desc     : Randomized bench for instruction_prefetch_buffer with a queue model.
// Revision : 1.0 - initial release
// =============================================================================
module tb_instruction_prefetch_buffer;

    localparam int          AW    = 8;
    localparam int          DEPTH = 4;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          halt = 1'b0;
    logic          redirect = 1'b0;
    logic [AW-1:0] redirect_pc = '0;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_valid = 1'b0;
    logic [31:0]   mem_instr = '0;
    logic          instr_valid;
    logic          instr_ready = 1'b0;
    logic [31:0]   instr;
    logic [AW-1:0] instr_pc;
    logic [2:0]    count;

    instruction_prefetch_buffer #(
        .INSTR_ADDR_WIDTH(AW),
        .DEPTH(DEPTH),
        .RESET_PC(0)
    ) u_dut (
        .clk(clk),
        .rst(rst),
        .halt(halt),
        .redirect(redirect),
        .redirect_pc(redirect_pc),
        .mem_req(mem_req),
        .mem_addr(mem_addr),
        .mem_valid(mem_valid),
        .mem_instr(mem_instr),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .instr(instr),
        .instr_pc(instr_pc),
        .count(count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: queue of fetched words plus "request in flight" / "drop it" flags.
    typedef struct {
        logic [31:0]   ins;
        logic [AW-1:0] pc;
    } ent_t;

    ent_t          q[$];
    logic [AW-1:0] m_pc;
    logic [AW-1:0] m_req_pc;
    bit            m_out;
    bit            m_drop;

    int resp_timer = 0;
    int lat_max    = 1;
    int p_ready    = 100;
    int p_redir    = 0;
    int p_halt     = 0;

    task automatic model_reset();
        q.delete();
        m_pc     = '0;
        m_req_pc = '0;
        m_out    = 1'b0;
        m_drop   = 1'b0;
    endtask

    task automatic step(input bit r = 1'b1);
        bit exp_req;
        bit pop;
        @(negedge clk);
        rst       = r;
        mem_valid = 1'b0;
        if (resp_timer > 0) begin
            resp_timer--;
            if (resp_timer == 0) begin
                mem_valid = 1'b1;
                mem_instr = $urandom;
            end
        end
        instr_ready = ($urandom_range(99) < p_ready);
        redirect    = ($urandom_range(99) < p_redir);
        redirect_pc = ($urandom_range(3) == 0) ? 8'hFF : AW'($urandom);
        halt        = ($urandom_range(99) < p_halt);
        if (!rst) model_reset();
        #1;
        exp_req = rst && !halt && !redirect && !m_out && (q.size() < DEPTH);
        check("mem_req", 32'(mem_req), 32'(exp_req));
        check("mem_addr", 32'(mem_addr), 32'(m_pc));
        check("count", 32'(count), 32'(q.size()));
        check("instr_valid", 32'(instr_valid), 32'(q.size() != 0));
        if (q.size() != 0) begin
            check("instr", instr, q[0].ins);
            check("instr_pc", 32'(instr_pc), 32'(q[0].pc));
        end else begin
            check("instr_nop", instr, NOP);
            check("instr_pc0", 32'(instr_pc), 32'd0);
        end
        if (mem_req && resp_timer == 0) resp_timer = $urandom_range(lat_max, 1);

        if (!rst) begin
            model_reset();
        end else if (redirect) begin
            q.delete();
            m_pc = redirect_pc;
            if (m_out && mem_valid) begin
                m_out  = 1'b0;
                m_drop = 1'b0;
            end else if (m_out) begin
                m_drop = 1'b1;
            end
        end else begin
            pop = (q.size() != 0) && instr_ready;
            if (pop) void'(q.pop_front());
            if (m_out && mem_valid) begin
                if (!m_drop) q.push_back(ent_t'{mem_instr, m_req_pc});
                m_out  = 1'b0;
                m_drop = 1'b0;
            end
            if (exp_req) begin
                m_out    = 1'b1;
                m_req_pc = m_pc;
                m_pc     = m_pc + 1'b1;
            end
        end
    endtask

    initial begin
        int guard;
        model_reset();
        #2 rst = 1'b0;
        repeat (3) step(1'b0);

        // Streaming with single-cycle memory and an always-ready decoder.
        lat_max = 1; p_ready = 100; p_redir = 0; p_halt = 0;
        repeat (20) step();

        // Back-pressure: fill the queue, then drain it.
        p_ready = 0;
        repeat (12) step();
        p_ready = 100;
        repeat (10) step();

        // Random mix of latency, stalls, halts and redirects (incl. 8'hFF wrap).
        lat_max = 3; p_ready = 60; p_redir = 8; p_halt = 10;
        repeat (2000) step();

        // Reset in the middle of a fetch; the late response must be ignored.
        p_redir = 0; p_halt = 0; p_ready = 50;
        guard = 0;
        while (!m_out && guard < 10) begin
            step();
            guard++;
        end
        check("wait_outstanding", 32'(m_out), 32'd1);
        repeat (2) step(1'b0);
        p_halt = 100;
        repeat (5) step();
        p_halt = 0; p_ready = 70;
        repeat (40) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
